// File: rtl/sweeper_pkg.sv
// Shared types, table-width helper and reference truth-table IDs for the sweeper family.
package sweeper_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StApply,
      StDone
   } state_e;

   // Truth-table width for a given number of DUT inputs.
   function automatic int unsigned tw(input int unsigned n_in);
      return 32'd1 << n_in;
   endfunction

   localparam logic [7:0] TT_MAJ3 = 8'hE8;
   localparam logic [7:0] TT_AND3 = 8'h80;
   localparam logic [7:0] TT_XOR3 = 8'h96;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, DUT-drive and result signals of one truth-table sweeper.
interface truth_table_sweeper_if
   import sweeper_pkg::*;
#(
   parameter int unsigned N_IN = 3
);
   localparam int unsigned TW = tw(N_IN);

   logic            start;
   logic            abort;
   logic [TW-1:0]   expected;
   logic            dut_out;
   logic [N_IN-1:0] dut_in;
   logic            busy;
   logic            done;
   logic [TW-1:0]   table_out;
   logic            pass;
   logic [TW-1:0]   mismatch;

   modport master (
      output start, abort, expected, dut_out,
      input  dut_in, busy, done, table_out, pass, mismatch
   );

   modport slave (
      input  start, abort, expected, dut_out,
      output dut_in, busy, done, table_out, pass, mismatch
   );

endinterface

// File: rtl/settle_timer.sv
// Loadable 8-bit up-counter; tc flags that the count has reached limit.
module settle_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       load,
   input  logic       en,
   input  logic [7:0] load_value,
   input  logic [7:0] limit,
   output logic       tc
);

   logic [7:0] count_q;

   // Count register: clear beats load beats increment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= 8'd0;
      end else if (clear) begin
         count_q <= 8'd0;
      end else if (load) begin
         count_q <= load_value;
      end else if (en) begin
         count_q <= count_q + 8'd1;
      end
   end

   assign tc = (count_q == limit);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input combination into a combinational DUT, builds its truth table and
// compares it with a reference latched at start.
module truth_table_sweeper
   import sweeper_pkg::*;
#(
   parameter int unsigned N_IN          = 3,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   truth_table_sweeper_if.slave bus
);

   localparam int unsigned     TW       = tw(N_IN);
   localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TW - 1);
   localparam logic [7:0]      SETTLE   = 8'(SETTLE_CYCLES);

   state_e          state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic [TW-1:0]   scratch_q, scratch_d;
   logic [TW-1:0]   exp_q, exp_d;
   logic [TW-1:0]   table_q, table_d;
   logic            pass_q, pass_d;
   logic [TW-1:0]   mism_q, mism_d;
   logic [TW-1:0]   captured;
   logic            timer_clear, timer_en, settled;

   settle_timer u_settle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (timer_clear),
      .load       (1'b0),
      .en         (timer_en),
      .load_value (8'd0),
      .limit      (SETTLE),
      .tc         (settled)
   );

   // Sweep FSM; results are computed on the final capture so they are valid in the done cycle.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      scratch_d   = scratch_q;
      exp_d       = exp_q;
      table_d     = table_q;
      pass_d      = pass_q;
      mism_d      = mism_q;
      timer_clear = 1'b1;
      timer_en    = 1'b0;
      captured          = scratch_q;
      captured[idx_q]   = bus.dut_out;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StApply;
               idx_d   = '0;
               exp_d   = bus.expected;
            end
         end
         StApply: begin
            // Abort wins over a capture landing in the same cycle.
            if (bus.abort) begin
               state_d = StIdle;
               idx_d   = '0;
            end else if (settled) begin
               scratch_d = captured;
               if (idx_q == IDX_LAST) begin
                  state_d = StDone;
                  table_d = captured;
                  pass_d  = (captured == exp_q);
                  mism_d  = captured ^ exp_q;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               timer_clear = 1'b0;
               timer_en    = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
            idx_d   = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         scratch_q <= '0;
         exp_q     <= '0;
         table_q   <= '0;
         pass_q    <= 1'b0;
         mism_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         scratch_q <= scratch_d;
         exp_q     <= exp_d;
         table_q   <= table_d;
         pass_q    <= pass_d;
         mism_q    <= mism_d;
      end
   end

   assign bus.busy      = (state_q == StApply);
   assign bus.done      = (state_q == StDone);
   assign bus.dut_in    = (state_q == StApply) ? idx_q : '0;
   assign bus.table_out = table_q;
   assign bus.pass      = pass_q;
   assign bus.mismatch  = mism_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with majority/AND (S=2) and XOR (S=0) DUT models.
module tb_truth_table_sweeper;
   import sweeper_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic model_and;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   truth_table_sweeper_if #(.N_IN(3)) bus ();
   truth_table_sweeper_if #(.N_IN(3)) bus0 ();

   function automatic logic nor2(input logic a, input logic b);
      return ~(a | b);
   endfunction

   // Majority built from NOT/NOR gates only.
   function automatic logic maj_net(input logic [2:0] v);
      logic ab, ac, bc;
      ab = nor2(~v[2], ~v[1]);
      ac = nor2(~v[2], ~v[0]);
      bc = nor2(~v[1], ~v[0]);
      return ~nor2(~nor2(ab, ac), bc);
   endfunction

   assign bus.dut_out  = model_and ? (&bus.dut_in) : maj_net(bus.dut_in);
   assign bus0.dut_out = ^bus0.dut_in;

   truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(2)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(0)) u_dut_fast (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Full default-settle sweep starting now; expected is scrambled mid-sweep.
   task automatic sweep(input logic [7:0] exp_val, input logic [7:0] exp_tab,
                        input logic exp_pass, input logic [7:0] exp_mis);
      bus.expected = exp_val;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.expected = ~exp_val;
      for (int k = 1; k <= 24; k++) begin
         check("sweep_dut_in", 32'(bus.dut_in), 32'((k - 1) / 3));
         check("sweep_busy", 32'(bus.busy), 32'd1);
         check("sweep_no_done", 32'(bus.done), 32'd0);
         @(negedge clk);
      end
      check("sweep_done", 32'(bus.done), 32'd1);
      check("sweep_busy_low", 32'(bus.busy), 32'd0);
      check("sweep_dut_in_idle", 32'(bus.dut_in), 32'd0);
      check("sweep_table", 32'(bus.table_out), 32'(exp_tab));
      check("sweep_pass", 32'(bus.pass), 32'(exp_pass));
      check("sweep_mismatch", 32'(bus.mismatch), 32'(exp_mis));
      @(negedge clk);
      check("sweep_done_pulse", 32'(bus.done), 32'd0);
   endtask

   initial begin
      logic seen_done;
      rst_n         = 1'b0;
      model_and     = 1'b0;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.expected  = '0;
      bus0.start    = 1'b0;
      bus0.abort    = 1'b0;
      bus0.expected = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset values
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_dut_in", 32'(bus.dut_in), 32'd0);
      check("rst_table", 32'(bus.table_out), 32'd0);
      check("rst_pass", 32'(bus.pass), 32'd0);
      check("rst_mismatch", 32'(bus.mismatch), 32'd0);

      // Majority, matching and non-matching references
      sweep(TT_MAJ3, 8'hE8, 1'b1, 8'h00);
      sweep(8'hE9, 8'hE8, 1'b0, 8'h01);

      // Zero settle, XOR DUT
      bus0.expected = TT_XOR3;
      bus0.start    = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         check("fast_dut_in", 32'(bus0.dut_in), 32'(k - 1));
         check("fast_no_done", 32'(bus0.done), 32'd0);
         @(negedge clk);
      end
      check("fast_done", 32'(bus0.done), 32'd1);
      check("fast_table", 32'(bus0.table_out), 32'h96);
      check("fast_pass", 32'(bus0.pass), 32'd1);
      check("fast_mismatch", 32'(bus0.mismatch), 32'd0);

      // Starts at cycle 5 and in the done cycle are ignored; cycle 26 start is taken
      bus.expected = TT_MAJ3;
      bus.start    = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 25; k++) begin
         bus.start = (k == 5 || k == 25);
         if (k == 6) check("ign_dut_in", 32'(bus.dut_in), 32'd1);
         if (k == 25) check("ign_done", 32'(bus.done), 32'd1);
         @(negedge clk);
      end
      bus.start = 1'b1;
      check("ign_busy_26", 32'(bus.busy), 32'd0);
      check("ign_done_26", 32'(bus.done), 32'd0);
      @(negedge clk);
      bus.start = 1'b0;
      check("restart_busy", 32'(bus.busy), 32'd1);
      check("restart_dut_in", 32'(bus.dut_in), 32'd0);
      seen_done = 1'b0;
      for (int k = 0; k < 40 && !seen_done; k++) begin
         @(negedge clk);
         seen_done = bus.done;
      end
      check("restart_done_seen", 32'(seen_done), 32'd1);
      check("restart_pass", 32'(bus.pass), 32'd1);
      @(negedge clk);

      // AND DUT aborted at cycle 10 leaves previous results intact
      model_and    = 1'b1;
      bus.expected = TT_AND3;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_dut_in", 32'(bus.dut_in), 32'd0);
      seen_done = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (bus.done) seen_done = 1'b1;
         @(negedge clk);
      end
      check("abort_no_done", 32'(seen_done), 32'd0);
      check("abort_table", 32'(bus.table_out), 32'hE8);
      check("abort_pass", 32'(bus.pass), 32'd1);

      // Reset at cycle 12 of a sweep
      model_and    = 1'b0;
      bus.expected = TT_MAJ3;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (11) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mrst_busy", 32'(bus.busy), 32'd0);
      check("mrst_done", 32'(bus.done), 32'd0);
      check("mrst_dut_in", 32'(bus.dut_in), 32'd0);
      check("mrst_table", 32'(bus.table_out), 32'd0);
      check("mrst_pass", 32'(bus.pass), 32'd0);
      check("mrst_mismatch", 32'(bus.mismatch), 32'd0);
      @(negedge clk);
      check("mrst_done_after", 32'(bus.done), 32'd0);
      sweep(TT_MAJ3, 8'hE8, 1'b1, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
